id_ex_latch: RTL and testbench
==============================

ID_EX_LATCH -- requirements
Module: id_ex_latch

Interface
REQ-001 Parameter DATA_W, default 32: width of npc, read-data and sign-extended immediate paths.
REQ-002 Parameter REG_W, default 5: width of register-specifier fields.
REQ-003 Parameter CNT_W, default 8: width of the bubble counter.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 stall  input  1  hold all stage registers unchanged.
REQ-007 flush  input  1  load a bubble (all control zero, valid zero).
REQ-008 id_valid  input  1  decode stage holds a real instruction.
REQ-009 ctlwb_in  input  2  WB controls {regwrite, memtoreg}.
REQ-010 ctlm_in  input  3  MEM controls {branch, memread, memwrite}.
REQ-011 ctlex_in  input  4  EX controls {regdst, aluop[1:0], alusrc}.
REQ-012 npc_in, rdata1_in, rdata2_in, sext_in  input  DATA_W each  next PC, register-file reads, sign-extended 16-bit immediate from S_EXTEND.
REQ-013 rt_in, rd_in  input  REG_W each  instruction fields [20:16], [15:11].
REQ-014 ctlwb_out, ctlm_out, ctlex_out, npc_out, rdata1_out, rdata2_out, sext_out, rt_out, rd_out  output  same widths as inputs  registered copies.
REQ-015 ex_valid  output  1  EX stage holds a real instruction.
REQ-016 bubble_cnt  output  CNT_W  count of bubbles inserted since reset.

Function
REQ-017 Latency SHALL be exactly one clk cycle from input to corresponding output when stall=0 and flush=0.
REQ-018 With flush=1, next edge SHALL load ctlwb/ctlm/ctlex=0 and ex_valid=0; data fields SHALL be loaded from inputs (don't-care for EX).
REQ-019 With stall=1 and flush=0, every output register SHALL retain its value.
REQ-020 flush=1 SHALL take priority over stall=1 when both asserted in the same cycle.
REQ-021 With stall=0, flush=0, ex_valid SHALL load id_valid; control bundles SHALL load their inputs only if id_valid=1, else zero.
REQ-022 bubble_cnt SHALL increment by 1 on each edge where a bubble is loaded (flush=1, or stall=0 with id_valid=0).
REQ-023 bubble_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 No combinational path SHALL exist from any input to any output.
REQ-025 sext_in SHALL pass unmodified; no re-extension or truncation inside the block.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) clear every output, including ex_valid and bubble_cnt, to zero.
REQ-027 Reset deassertion SHALL take effect at the first rising clk edge after rst_n rises; reset mid-stall SHALL discard held contents.

Configuration
REQ-028 Macro ID_EX_RS_FWD_EN defined: additional ports rs_in (input, REG_W, field [25:21]) and rs_out (output, REG_W) SHALL exist and follow REQ-017..REQ-019 and REQ-026 for forwarding-unit use.
REQ-029 Macro ID_EX_RS_FWD_EN undefined: rs_in/rs_out SHALL NOT exist; all other behaviour identical.

Structure
REQ-030 Package mips_pkg SHALL hold DATA_W/REG_W defaults, control-bundle widths, ctlex/ctlm/ctlwb bit-position constants, and the all-zero bubble constants.
REQ-031 One sub-module pipe_reg (parameterised width, enable, synchronous clear, async active-low reset) SHALL implement each stored field.

Verification
REQ-032 Reset: rst_n=0 mid-cycle with outputs nonzero -> all outputs 0 before next edge, bubble_cnt=0.
REQ-033 Pass-through: id_valid=1, sext_in=32'hFFFF8304, ctlex_in=4'b0011, rt_in=5'd9 -> one edge later sext_out=32'hFFFF8304, ctlex_out=4'b0011, rt_out=9, ex_valid=1.
REQ-034 Stall: load sext_in=32'h00003304, then stall=1 for 3 edges with sext_in=32'h0000733D -> sext_out stays 32'h00003304, bubble_cnt unchanged.
REQ-035 Flush vs stall: stall=1, flush=1, ctlwb_in=2'b11 -> next edge ctlwb_out=0, ex_valid=0, bubble_cnt+1.
REQ-036 Saturation: CNT_W=2, id_valid=0 for 6 edges -> bubble_cnt 1,2,3,3,3,3.
REQ-037 With ID_EX_RS_FWD_EN: rs_in=5'd17 -> rs_out=17 one edge later; held under stall; 0 on reset.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: default widths, control-bundle layouts
// and the all-zero bubble constants used by the pipeline latches.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;
  localparam int CNT_W_DEF  = 8;

  localparam int CTLWB_W = 2;
  localparam int CTLM_W  = 3;
  localparam int CTLEX_W = 4;

  // ctlwb = {regwrite, memtoreg}
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // ctlm = {branch, memread, memwrite}
  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  // ctlex = {regdst, aluop[1:0], alusrc}
  localparam int EX_REGDST  = 3;
  localparam int EX_ALUOP_H = 2;
  localparam int EX_ALUOP_L = 1;
  localparam int EX_ALUSRC  = 0;

  typedef logic [CTLWB_W-1:0] ctlwb_t;
  typedef logic [CTLM_W-1:0]  ctlm_t;
  typedef logic [CTLEX_W-1:0] ctlex_t;

  localparam ctlwb_t CTLWB_BUBBLE = '0;
  localparam ctlm_t  CTLM_BUBBLE  = '0;
  localparam ctlex_t CTLEX_BUBBLE = '0;

endpackage

// File: rtl/pipe_reg.sv
// Single pipeline field register: async active-low reset, synchronous clear
// (wins over enable) and load enable.
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline latch with stall, flush-to-bubble and a saturating bubble
// counter. Define ID_EX_RS_FWD_EN to add the rs field for forwarding.
module id_ex_latch
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [CTLWB_W-1:0] ctlwb_in,
  input  logic [CTLM_W-1:0]  ctlm_in,
  input  logic [CTLEX_W-1:0] ctlex_in,
  input  logic [DATA_W-1:0] npc_in,
  input  logic [DATA_W-1:0] rdata1_in,
  input  logic [DATA_W-1:0] rdata2_in,
  input  logic [DATA_W-1:0] sext_in,
  input  logic [REG_W-1:0]  rt_in,
  input  logic [REG_W-1:0]  rd_in,
`ifdef ID_EX_RS_FWD_EN
  input  logic [REG_W-1:0]  rs_in,
  output logic [REG_W-1:0]  rs_out,
`endif
  output logic [CTLWB_W-1:0] ctlwb_out,
  output logic [CTLM_W-1:0]  ctlm_out,
  output logic [CTLEX_W-1:0] ctlex_out,
  output logic [DATA_W-1:0] npc_out,
  output logic [DATA_W-1:0] rdata1_out,
  output logic [DATA_W-1:0] rdata2_out,
  output logic [DATA_W-1:0] sext_out,
  output logic [REG_W-1:0]  rt_out,
  output logic [REG_W-1:0]  rd_out,
  output logic              ex_valid,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // A bubble is loaded on flush (even when stalled) or when an unstalled
  // decode stage offers no real instruction.
  logic bubble;
  logic ctl_en;
  logic data_en;
  logic cnt_en;
  logic [CNT_W-1:0] cnt_next;

  assign bubble   = flush | (~stall & ~id_valid);
  assign ctl_en   = ~stall;
  assign data_en  = ~stall | flush;
  assign cnt_en   = bubble & (bubble_cnt != {CNT_W{1'b1}});
  assign cnt_next = bubble_cnt + CNT_W'(1);

  pipe_reg #(.W(CTLWB_W)) u_ctlwb (
    .clk(clk), .rst_n(rst_n), .en(ctl_en), .clr(bubble),
    .d(ctlwb_in), .q(ctlwb_out));

  pipe_reg #(.W(CTLM_W)) u_ctlm (
    .clk(clk), .rst_n(rst_n), .en(ctl_en), .clr(bubble),
    .d(ctlm_in), .q(ctlm_out));

  pipe_reg #(.W(CTLEX_W)) u_ctlex (
    .clk(clk), .rst_n(rst_n), .en(ctl_en), .clr(bubble),
    .d(ctlex_in), .q(ctlex_out));

  pipe_reg #(.W(1)) u_valid (
    .clk(clk), .rst_n(rst_n), .en(ctl_en), .clr(flush),
    .d(id_valid), .q(ex_valid));

  pipe_reg #(.W(DATA_W)) u_npc (
    .clk(clk), .rst_n(rst_n), .en(data_en), .clr(1'b0),
    .d(npc_in), .q(npc_out));

  pipe_reg #(.W(DATA_W)) u_rdata1 (
    .clk(clk), .rst_n(rst_n), .en(data_en), .clr(1'b0),
    .d(rdata1_in), .q(rdata1_out));

  pipe_reg #(.W(DATA_W)) u_rdata2 (
    .clk(clk), .rst_n(rst_n), .en(data_en), .clr(1'b0),
    .d(rdata2_in), .q(rdata2_out));

  pipe_reg #(.W(DATA_W)) u_sext (
    .clk(clk), .rst_n(rst_n), .en(data_en), .clr(1'b0),
    .d(sext_in), .q(sext_out));

  pipe_reg #(.W(REG_W)) u_rt (
    .clk(clk), .rst_n(rst_n), .en(data_en), .clr(1'b0),
    .d(rt_in), .q(rt_out));

  pipe_reg #(.W(REG_W)) u_rd (
    .clk(clk), .rst_n(rst_n), .en(data_en), .clr(1'b0),
    .d(rd_in), .q(rd_out));

`ifdef ID_EX_RS_FWD_EN
  pipe_reg #(.W(REG_W)) u_rs (
    .clk(clk), .rst_n(rst_n), .en(data_en), .clr(1'b0),
    .d(rs_in), .q(rs_out));
`endif

  // Enable drops at all-ones so the count saturates instead of wrapping.
  pipe_reg #(.W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst_n(rst_n), .en(cnt_en), .clr(1'b0),
    .d(cnt_next), .q(bubble_cnt));

endmodule

// File: tb/tb_id_ex_latch.sv
// Self-checking bench for id_ex_latch: directed scenarios plus randomized
// traffic against a transaction-level model; a CNT_W=2 instance checks saturation.
module tb_id_ex_latch;

  logic        clk;
  logic        rst_n;
  logic        stall, flush, id_valid;
  logic [1:0]  ctlwb_in;
  logic [2:0]  ctlm_in;
  logic [3:0]  ctlex_in;
  logic [31:0] npc_in, rdata1_in, rdata2_in, sext_in;
  logic [4:0]  rt_in, rd_in, rs_in;

  logic [1:0]  ctlwb_out, s_ctlwb_out;
  logic [2:0]  ctlm_out, s_ctlm_out;
  logic [3:0]  ctlex_out, s_ctlex_out;
  logic [31:0] npc_out, rdata1_out, rdata2_out, sext_out;
  logic [31:0] s_npc_out, s_rdata1_out, s_rdata2_out, s_sext_out;
  logic [4:0]  rt_out, rd_out, rs_out, s_rt_out, s_rd_out, s_rs_out;
  logic        ex_valid, s_ex_valid;
  logic [7:0]  bubble_cnt;
  logic [1:0]  s_bubble_cnt;

  id_ex_latch dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .ctlex_in(ctlex_in),
    .npc_in(npc_in), .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .sext_in(sext_in),
    .rt_in(rt_in), .rd_in(rd_in),
`ifdef ID_EX_RS_FWD_EN
    .rs_in(rs_in), .rs_out(rs_out),
`endif
    .ctlwb_out(ctlwb_out), .ctlm_out(ctlm_out), .ctlex_out(ctlex_out),
    .npc_out(npc_out), .rdata1_out(rdata1_out), .rdata2_out(rdata2_out),
    .sext_out(sext_out), .rt_out(rt_out), .rd_out(rd_out),
    .ex_valid(ex_valid), .bubble_cnt(bubble_cnt));

  id_ex_latch #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .ctlex_in(ctlex_in),
    .npc_in(npc_in), .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .sext_in(sext_in),
    .rt_in(rt_in), .rd_in(rd_in),
`ifdef ID_EX_RS_FWD_EN
    .rs_in(rs_in), .rs_out(s_rs_out),
`endif
    .ctlwb_out(s_ctlwb_out), .ctlm_out(s_ctlm_out), .ctlex_out(s_ctlex_out),
    .npc_out(s_npc_out), .rdata1_out(s_rdata1_out), .rdata2_out(s_rdata2_out),
    .sext_out(s_sext_out), .rt_out(s_rt_out), .rd_out(s_rd_out),
    .ex_valid(s_ex_valid), .bubble_cnt(s_bubble_cnt));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: what the EX stage should hold after each edge.
  logic [1:0]  m_wb;
  logic [2:0]  m_m;
  logic [3:0]  m_ex;
  logic [31:0] m_npc, m_r1, m_r2, m_sx;
  logic [4:0]  m_rt, m_rd, m_rs;
  logic        m_v;
  int          m_cnt, m_cnt_sat;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic modelReset();
    m_wb = '0; m_m = '0; m_ex = '0; m_v = 1'b0;
    m_npc = '0; m_r1 = '0; m_r2 = '0; m_sx = '0;
    m_rt = '0; m_rd = '0; m_rs = '0;
    m_cnt = 0; m_cnt_sat = 0;
  endtask

  task automatic modelEdge();
    logic is_bubble;
    is_bubble = flush || (!stall && !id_valid);
    if (flush || !stall) begin
      m_npc = npc_in; m_r1 = rdata1_in; m_r2 = rdata2_in; m_sx = sext_in;
      m_rt = rt_in; m_rd = rd_in; m_rs = rs_in;
      m_v  = !flush && id_valid;
      m_wb = m_v ? ctlwb_in : 2'b00;
      m_m  = m_v ? ctlm_in  : 3'b000;
      m_ex = m_v ? ctlex_in : 4'b0000;
    end
    if (is_bubble) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt_sat < 3) m_cnt_sat++;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("ctlwb", 64'(ctlwb_out), 64'(m_wb));
    check("ctlm", 64'(ctlm_out), 64'(m_m));
    check("ctlex", 64'(ctlex_out), 64'(m_ex));
    check("npc", 64'(npc_out), 64'(m_npc));
    check("rdata1", 64'(rdata1_out), 64'(m_r1));
    check("rdata2", 64'(rdata2_out), 64'(m_r2));
    check("sext", 64'(sext_out), 64'(m_sx));
    check("rt", 64'(rt_out), 64'(m_rt));
    check("rd", 64'(rd_out), 64'(m_rd));
    check("ex_valid", 64'(ex_valid), 64'(m_v));
    check("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
    check("sat_bubble_cnt", 64'(s_bubble_cnt), 64'(m_cnt_sat));
    check("sat_ctlwb", 64'(s_ctlwb_out), 64'(m_wb));
    check("sat_sext", 64'(s_sext_out), 64'(m_sx));
`ifdef ID_EX_RS_FWD_EN
    check("rs", 64'(rs_out), 64'(m_rs));
    check("sat_rs", 64'(s_rs_out), 64'(m_rs));
`endif
  endtask

  task automatic applyStimulus(input logic st, input logic fl, input logic iv);
    stall = st; flush = fl; id_valid = iv;
    ctlwb_in = 2'($urandom); ctlm_in = 3'($urandom); ctlex_in = 4'($urandom);
    npc_in = $urandom; rdata1_in = $urandom; rdata2_in = $urandom; sext_in = $urandom;
    rt_in = 5'($urandom); rd_in = 5'($urandom); rs_in = 5'($urandom);
  endtask

  // One edge: model follows the inputs seen at the edge, outputs checked 1 unit later.
  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  int saved_cnt;
  int sat_exp[6] = '{1, 2, 3, 3, 3, 3};

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    modelReset();
    #2;
    checkOutput();
    #10 rst_n = 1'b1;

    // Pass-through with a negative immediate
    applyStimulus(1'b0, 1'b0, 1'b1);
    sext_in = 32'hFFFF8304; ctlex_in = 4'b0011; rt_in = 5'd9; rs_in = 5'd17;
    stepCycle();
    check("pass_sext", 64'(sext_out), 64'h0000_0000_FFFF_8304);
    check("pass_ctlex", 64'(ctlex_out), 64'h3);
    check("pass_rt", 64'(rt_out), 64'd9);
    check("pass_valid", 64'(ex_valid), 64'd1);
`ifdef ID_EX_RS_FWD_EN
    check("pass_rs", 64'(rs_out), 64'd17);
`endif

    // Stall holds for three edges
    applyStimulus(1'b0, 1'b0, 1'b1);
    sext_in = 32'h00003304;
    stepCycle();
    saved_cnt = m_cnt;
    applyStimulus(1'b1, 1'b0, 1'b1);
    sext_in = 32'h0000733D;
    repeat (3) stepCycle();
    check("stall_sext", 64'(sext_out), 64'h3304);
    check("stall_cnt", 64'(bubble_cnt), 64'(saved_cnt));

    // Flush beats stall
    applyStimulus(1'b1, 1'b1, 1'b1);
    ctlwb_in = 2'b11;
    stepCycle();
    check("flush_ctlwb", 64'(ctlwb_out), 64'd0);
    check("flush_valid", 64'(ex_valid), 64'd0);
    check("flush_cnt", 64'(bubble_cnt), 64'(saved_cnt + 1));

    // Load a real instruction, then reset asynchronously mid-stall
    applyStimulus(1'b0, 1'b0, 1'b1);
    ctlwb_in = 2'b11; npc_in = 32'h1234_5678;
    stepCycle();
    applyStimulus(1'b1, 1'b0, 1'b1);
    #3 rst_n = 1'b0;
    #1 modelReset();
    checkOutput();
    check("rst_npc", 64'(npc_out), 64'd0);
    #2 rst_n = 1'b1;

    // Saturation on the CNT_W=2 instance
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      stepCycle();
      check("sat_seq", 64'(s_bubble_cnt), 64'(sat_exp[i]));
    end

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom % 4) == 0, ($urandom % 6) == 0, ($urandom % 4) != 0);
      stepCycle();
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
